demux_feeder_10b: RTL and testbench
===================================

# demux_feeder_10b

Upstream stage of the 1-to-4 10-bit demultiplexer: accepts a stream of 10-bit samples over a valid/ready handshake and buffers them in a 4-entry FIFO. It drives the demux data word `X` and the 2-bit `select`, distributing samples round-robin over the enabled channels. Disabled channels are skipped. A `frame_done` pulse marks the last channel of each rotation, so downstream logic knows when all four of A..D hold a fresh set of samples.

## Interface
- `WIDTH`, 10, sample width; must match the demux data width.
- `DEPTH`, 4, FIFO entries; must be a power of 2, minimum 2.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `in_data` input WIDTH: incoming sample.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: FIFO can accept a sample this cycle.
- `chan_en` input 4: per-channel enable; bit i enables channel i (A=0 … D=3).
- `X` output WIDTH: sample presented to the demux (registered).
- `select` output 2: channel index for `X` (registered).
- `out_valid` output 1: `X`/`select` carry a new sample this cycle (registered).
- `frame_done` output 1: one-cycle pulse, coincident with `out_valid`, when the emitted channel is the highest enabled channel.

## Operation
- Reset values:
  - `X=0`, `select=0`, `out_valid=0`, `frame_done=0`.
  - FIFO empty (count 0), rotation pointer `ptr=0`.
  - `in_ready=0` while `reset` is high.
- Push: occurs when `in_valid && in_ready`.
  - `in_ready = !full`, combinational from the FIFO count.
  - When the FIFO is full, a same-cycle pop does not open a slot. `in_ready` stays 0 that cycle.
- Pop/emit: occurs in any cycle where the FIFO is non-empty and `chan_en != 0`.
  - Emitted channel `ch` = first set bit of `chan_en` at or after `ptr`, searching cyclically 0→1→2→3→0.
  - Register `X <= head`, `select <= ch`, `out_valid <= 1`, `ptr <= (ch+1) mod 4`.
  - `frame_done <= 1` iff no bit of `chan_en` above `ch` is set.
- Idle: the FIFO is empty or `chan_en == 0`.
  - `X <= 0`, `out_valid <= 0`, `frame_done <= 0`; `select` and `ptr` hold.
  - The FIFO holds its contents; with `chan_en == 0`, samples are retained, not dropped.
- `chan_en` may change on any cycle. The new value applies to the very next pop, and `ptr` is not reset.
- Reset mid-operation discards all buffered samples and returns every output to its reset value on the next edge.
- Arithmetic:
  - FIFO read/write pointers are `log2(DEPTH)` bits and wrap naturally.
  - The count is `log2(DEPTH)+1` bits.
  - No overflow or underflow is possible under the handshake rules.

## Timing
- Latency, push into an empty FIFO at edge N:
  - Sample appears on `X` with `out_valid` after edge N+1.
  - The demux captures it at edge N+2.
- Throughput: one sample per cycle sustained; simultaneous push and pop when not full keeps the count constant.
- Full at DEPTH entries: `in_ready` is low. Empty: no emit, `X = 0`.
- `frame_done` and `out_valid` are asserted in the same cycle, never separately.

## Structure
- Shared package constants:
  - `WIDTH_SAMPLE=10`, `NUM_CH=4`, `FIFO_DEPTH=4`.
  - Channel index constants `CH_A..CH_D` (0..3), also used by the demux.
- Sub-module: `sample_fifo`, a synchronous FIFO with WIDTH/DEPTH parameters and push/pop/full/empty/count ports.
- Top level holds the channel picker (priority search from `ptr`) and the output registers.

## Test plan
- Reset, all channels enabled:
  - After reset, `in_ready=1`, `X=0`, `out_valid=0`.
  - Push 0x001, 0x002, 0x003, 0x004 on consecutive cycles → `select` sequence 0,1,2,3, `X` matching, `frame_done` only with `select=3`.
- Gap handling: `chan_en=4'b1010`, push 0x3FF, 0x155, 0x2AA → `select` 1,3,1; `frame_done` on the 0x155 emission only.
- Backpressure: `chan_en=0`, push 5 samples → `in_ready` drops after the 4th. Then set `chan_en=4'hF` → 4 samples emitted in order 1..4, the 5th accepted once `in_ready` returns.
- Empty/idle: single push, then none → exactly one `out_valid` cycle; afterwards `X=0` and `select` holds its last value.
- Mid-run reset: fill 3 entries, assert `reset` for one cycle → all outputs 0 and FIFO empty. Next push emits on `select=0`.
- `chan_en` change: emitting on ch1 with `ptr=2`, change `chan_en` to `4'b0001` → the next sample goes to ch0 with `frame_done=1`.

Source files
------------

// File: rtl/demux_feeder_10b_pkg.sv
// -----------------------------------------------------------------------------
// demux_feeder_10b_pkg
// Shared constants and helpers for the 1-to-4 10-bit demux and its feeder.
//   WIDTH_SAMPLE : sample width carried to the demux
//   NUM_CH       : number of demux output channels (A..D)
//   FIFO_DEPTH   : default feeder FIFO depth
//   CH_A..CH_D   : channel indices, shared with the demux select decoding
//   pick_channel : cyclic first-set-bit search starting at a rotation pointer
//   is_last_channel : true when no enabled channel lies above the given one
// -----------------------------------------------------------------------------
package demux_feeder_10b_pkg;

    localparam int WIDTH_SAMPLE = 10;
    localparam int NUM_CH       = 4;
    localparam int FIFO_DEPTH   = 4;

    typedef logic [1:0] ch_idx_t;

    localparam ch_idx_t CH_A = 2'd0;
    localparam ch_idx_t CH_B = 2'd1;
    localparam ch_idx_t CH_C = 2'd2;
    localparam ch_idx_t CH_D = 2'd3;

    // First enabled channel at or after ptr, wrapping D -> A. When nothing is
    // enabled the result is ptr; callers only use it while en is non-zero.
    function automatic ch_idx_t pick_channel(input logic [3:0] en, input ch_idx_t ptr);
        ch_idx_t ch_v;
        ch_idx_t idx_v;
        logic    found_v;
        ch_v    = ptr;
        found_v = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx_v = ptr + k[1:0];
            if (!found_v && en[idx_v]) begin
                ch_v    = idx_v;
                found_v = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
        return ch_v;
    endfunction

    // A rotation ends on the highest enabled channel.
    function automatic logic is_last_channel(input logic [3:0] en, input ch_idx_t ch);
        logic last_v;
        last_v = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((k > int'(ch)) && en[k]) begin
                last_v = 1'b0;
            end else begin
                last_v = last_v;
            end
        end
        return last_v;
    endfunction

endpackage

// File: rtl/demux_feeder_10b_if.sv
// -----------------------------------------------------------------------------
// demux_feeder_10b_if
// Bundles the feeder's sample-in handshake, channel enables and demux-side
// outputs.
//   in_data/in_valid/in_ready : upstream valid/ready sample stream
//   chan_en                   : per-channel enable (bit i = channel i)
//   X/select/out_valid        : registered sample and channel index to demux
//   frame_done                : pulse on the last enabled channel of a rotation
// master = sample source / demux side, slave = the feeder itself.
// -----------------------------------------------------------------------------
interface demux_feeder_10b_if
    import demux_feeder_10b_pkg::*;
#(
    parameter int WIDTH = WIDTH_SAMPLE
);
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NUM_CH-1:0] chan_en;
    logic [WIDTH-1:0]  X;
    logic [1:0]        select;
    logic              out_valid;
    logic              frame_done;

    modport master (
        output in_data, in_valid, chan_en,
        input  in_ready, X, select, out_valid, frame_done
    );

    modport slave (
        input  in_data, in_valid, chan_en,
        output in_ready, X, select, out_valid, frame_done
    );
endinterface

// File: rtl/demux_feeder_10b_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO for the feeder. DEPTH must be a power of two (>= 2) so the
// read/write pointers wrap naturally.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push/wdata : write request and data (ignored while full)
//   pop/rdata  : read request (ignored while empty); rdata is the head entry
//   full/empty : status flags
//   count      : number of stored entries, log2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the flags so a misbehaving caller cannot corrupt the count.
    always_comb begin
        push_ok_s = push && (count_r != DEPTH_CNT);
        pop_ok_s  = pop && (count_r != {(AW + 1){1'b0}});
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == DEPTH_CNT);
    assign empty = (count_r == {(AW + 1){1'b0}});
    assign count = count_r;

endmodule

// File: rtl/demux_feeder_10b.sv
// -----------------------------------------------------------------------------
// demux_feeder_10b
// Feeds the 1-to-4 demux: buffers incoming samples in sample_fifo and emits
// one per cycle round-robin over the enabled channels, skipping disabled ones.
//   clk   : single clock, rising edge
//   reset : synchronous active-high; flushes the FIFO and clears outputs
//   bus   : demux_feeder_10b_if.slave
//           in_data/in_valid/in_ready : sample input handshake
//           chan_en                   : channel enables, may change any cycle
//           X/select/out_valid        : registered sample + channel to demux
//           frame_done                : with out_valid on highest enabled channel
// -----------------------------------------------------------------------------
module demux_feeder_10b
    import demux_feeder_10b_pkg::*;
#(
    parameter int WIDTH = WIDTH_SAMPLE,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    demux_feeder_10b_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] head_s;
    logic             full_s;
    logic             empty_s;
    logic [AW:0]      count_s;
    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    ch_idx_t          ch_s;
    logic             last_s;

    ch_idx_t          ptr_r;
    logic [WIDTH-1:0] x_r;
    ch_idx_t          select_r;
    logic             out_valid_r;
    logic             frame_done_r;

    sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (bus.in_data),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Handshake and pop decisions. The full flag and the count are decoded
    // independently inside the FIFO; either one reporting full blocks pushes.
    // A pop in the same cycle never opens a slot, keeping in_ready free of any
    // path from chan_en.
    always_comb begin
        ready_s = !reset && !full_s && (count_s != DEPTH_CNT);
        push_s  = bus.in_valid && ready_s;
        pop_s   = !empty_s && (bus.chan_en != 4'b0000);
    end

    // Channel picker: cyclic priority search from the rotation pointer.
    always_comb begin
        ch_s   = pick_channel(bus.chan_en, ptr_r);
        last_s = is_last_channel(bus.chan_en, ch_s);
    end

    // Output registers and rotation pointer; select and ptr hold while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r          <= {WIDTH{1'b0}};
            select_r     <= CH_A;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            ptr_r        <= CH_A;
        end else if (pop_s) begin
            x_r          <= head_s;
            select_r     <= ch_s;
            out_valid_r  <= 1'b1;
            frame_done_r <= last_s;
            ptr_r        <= ch_s + 2'd1;
        end else begin
            x_r          <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end
    end

    assign bus.in_ready   = ready_s;
    assign bus.X          = x_r;
    assign bus.select     = select_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_demux_feeder_10b.sv
// -----------------------------------------------------------------------------
// tb_demux_feeder_10b
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a negedge monitor pops and compares whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_demux_feeder_10b;
    import demux_feeder_10b_pkg::*;

    typedef struct {
        logic [9:0] data;
        logic [1:0] sel;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t exp_q[$];
    int   tests = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   base;

    always #5 clk = ~clk;

    demux_feeder_10b_if #(.WIDTH(10)) bus ();

    demux_feeder_10b #(.WIDTH(10), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_out(input logic [9:0] d, input logic [1:0] s, input logic f);
        exp_t e;
        e.data = d;
        e.sel  = s;
        e.fd   = f;
        exp_q.push_back(e);
    endtask

    // Present a sample and hold it until accepted (bounded wait).
    task automatic push(input logic [9:0] d);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            tests++;
            errors++;
            $display("FAIL push_timeout: in_ready stuck at 0 for sample 0x%0h, expected 1", d);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("frame_done_without_valid", {31'd0, bus.frame_done & ~bus.out_valid}, 32'd0);
            if (bus.out_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("X", {22'd0, bus.X}, {22'd0, e.data});
                    check("select", {30'd0, bus.select}, {30'd0, e.sel});
                    check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = 10'd0;
        bus.in_valid = 1'b0;
        bus.chan_en  = 4'hF;

        // Reset
        @(negedge clk);
        check("in_ready_during_reset", {31'd0, bus.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_X", {22'd0, bus.X}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_select", {30'd0, bus.select}, 32'd0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        cycles(1);

        // All channels enabled: 0,1,2,3 with frame_done on D
        expect_out(10'h001, 2'd0, 1'b0);
        expect_out(10'h002, 2'd1, 1'b0);
        expect_out(10'h003, 2'd2, 1'b0);
        expect_out(10'h004, 2'd3, 1'b1);
        for (int i = 1; i <= 4; i++) push(10'(i));
        cycles(4);
        @(negedge clk);
        check("idle_X", {22'd0, bus.X}, 32'd0);
        check("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle_select_hold", {30'd0, bus.select}, 32'd3);
        cycles(1);

        // Gaps: only B and D enabled
        bus.chan_en = 4'b1010;
        expect_out(10'h3FF, 2'd1, 1'b0);
        expect_out(10'h155, 2'd3, 1'b1);
        expect_out(10'h2AA, 2'd1, 1'b0);
        push(10'h3FF);
        push(10'h155);
        push(10'h2AA);
        cycles(4);

        // Backpressure: nothing enabled, ptr = 2
        bus.chan_en = 4'b0000;
        expect_out(10'h101, 2'd2, 1'b0);
        expect_out(10'h102, 2'd3, 1'b1);
        expect_out(10'h103, 2'd0, 1'b0);
        expect_out(10'h104, 2'd1, 1'b0);
        expect_out(10'h105, 2'd2, 1'b0);
        for (int i = 1; i <= 4; i++) push(10'h100 + 10'(i));
        check("in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        bus.in_data  = 10'h105;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycles(1);
            check("in_ready_held_full", {31'd0, bus.in_ready}, 32'd0);
            check("no_emit_disabled", {31'd0, bus.out_valid}, 32'd0);
        end
        bus.chan_en = 4'hF;
        push(10'h105);
        cycles(6);
        @(negedge clk);
        check("drain_select_hold", {30'd0, bus.select}, 32'd2);
        check("drain_X", {22'd0, bus.X}, 32'd0);
        cycles(1);

        // Single push then idle: exactly one out_valid, ptr = 3
        base = valid_cnt;
        expect_out(10'h0AB, 2'd3, 1'b1);
        push(10'h0AB);
        cycles(5);
        @(negedge clk);
        check("single_valid_count", 32'(valid_cnt - base), 32'd1);
        check("single_idle_X", {22'd0, bus.X}, 32'd0);
        check("single_select_hold", {30'd0, bus.select}, 32'd3);
        cycles(1);

        // Mid-run reset: move ptr to 3 first, then fill 3 and reset
        bus.chan_en = 4'b0100;
        expect_out(10'h0C4, 2'd2, 1'b1);
        push(10'h0C4);
        cycles(3);
        bus.chan_en = 4'b0000;
        push(10'h011);
        push(10'h022);
        push(10'h033);
        reset = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_X", {22'd0, bus.X}, 32'd0);
        check("mid_rst_select", {30'd0, bus.select}, 32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        base = valid_cnt;
        bus.chan_en = 4'hF;
        cycles(3);
        check("fifo_flushed", 32'(valid_cnt - base), 32'd0);
        expect_out(10'h1C5, 2'd0, 1'b0);
        push(10'h1C5);
        cycles(3);

        // chan_en change: emit on B (ptr -> 2), then only A enabled
        expect_out(10'h2E1, 2'd1, 1'b0);
        push(10'h2E1);
        cycles(1);
        bus.chan_en = 4'b0001;
        expect_out(10'h0D2, 2'd0, 1'b1);
        push(10'h0D2);
        cycles(4);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
